// File: rtl/scan_frame_builder.sv
// scan_frame_builder: binds per-shot distance results to revolution frames in a ping-pong point buffer.
// Latency: point written 1-2 cycles after its target_valid; frame_ready 1 cycle after zero rise; rd_data 1 cycle after rd_addr.
// Backpressure: none; the host must finish reading a frame before the next frame_ready.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   send_en                       emission enable; rising edge opens a shot window
//   zero_flag                     motor zero mark; rising edge closes the revolution
//   target_valid, target_pos      distance result pulse and value (mm)
//   alarm_dust                    dust alarm level, sampled when a window opens
//   frame_ready                   one-cycle pulse: a new frame is readable
//   frame_count/overflow/dust     descriptors of the readable frame, held until the next pulse
//   synced                        high once the first zero edge has been seen
//   rd_addr, rd_data              read port into the readable bank, 1-cycle latency
module scan_frame_builder #(
   parameter int          N_POINTS  = 1024,
   parameter int          AW        = 10,
   parameter int          TIMEOUT   = 64,
   parameter logic [15:0] NO_TARGET = 16'hFFFF,
   parameter logic [15:0] MAX_DIST  = 16'hFFFE
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          send_en,
   input  logic          zero_flag,
   input  logic          target_valid,
   input  logic [31:0]   target_pos,
   input  logic          alarm_dust,
   output logic          frame_ready,
   output logic [AW:0]   frame_count,
   output logic          frame_overflow,
   output logic [7:0]    frame_dust,
   output logic          synced,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data
);

   localparam int WCW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      IDLE  = 2'd1,
      WAIT  = 2'd2,
      WRITE = 2'd3
   } state_t;

   state_t         state, state_nxt;

   // Edge detection: prev is the registered copy, the live input is cur.
   logic           send_prev, zero_prev;
   logic           send_rise, zero_rise;

   logic [WCW-1:0] win_cnt, win_cnt_nxt;
   logic           dust_flag, dust_flag_nxt;
   logic [15:0]    point, point_nxt;
   logic [AW:0]    wr_ptr;
   logic           ovf_flag;
   logic [7:0]     dust_cnt;
   logic           wr_bank;
   logic           synced_nxt;

   logic           swap;
   logic           do_write;
   logic           mem_we;
   logic           full;
   logic [15:0]    wr_point;
   logic [15:0]    sat_pos;
   logic [AW:0]    ptr_after;
   logic           ovf_after;
   logic [7:0]     dust_after;

   // Both banks live in one array; the bank select is the address MSB.
   logic [15:0]    mem [0:2*N_POINTS-1];

   assign send_rise = send_en & ~send_prev;
   assign zero_rise = zero_flag & ~zero_prev;

   assign sat_pos = (target_pos > {16'd0, MAX_DIST}) ? MAX_DIST : target_pos[15:0];

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state, window handling and write request
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt     = state;
      win_cnt_nxt   = win_cnt;
      dust_flag_nxt = dust_flag;
      point_nxt     = point;
      synced_nxt    = synced;
      do_write      = 1'b0;
      wr_point      = point;
      swap          = 1'b0;

      case (state)
         SYNC: begin
            // The first zero edge only establishes alignment; no frame yet.
            if (zero_rise) begin
               synced_nxt = 1'b1;
               state_nxt  = IDLE;
            end
         end
         IDLE: begin
            state_nxt = IDLE;
         end
         WAIT: begin
            // A zero edge abandons the open window without writing.
            if (!zero_rise) begin
               if (send_rise) begin
                  // New emission before a result: the old shot is a miss.
                  do_write = 1'b1;
                  wr_point = NO_TARGET;
               end else if (target_valid && (win_cnt < WCW'(TIMEOUT))) begin
                  point_nxt = sat_pos;
                  state_nxt = WRITE;
               end else if (win_cnt >= WCW'(TIMEOUT)) begin
                  point_nxt = NO_TARGET;
                  state_nxt = WRITE;
               end else begin
                  win_cnt_nxt = win_cnt + 1'b1;
               end
            end
         end
         WRITE: begin
            // The write happens even on a zero edge; it lands in the old bank.
            do_write  = 1'b1;
            wr_point  = point;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = SYNC;
         end
      endcase

      // Zero edge handled before send edge so a coincident shot
      // opens its window in the new frame.
      if (state != SYNC) begin
         if (zero_rise) begin
            swap      = 1'b1;
            state_nxt = IDLE;
         end
         if (send_rise) begin
            win_cnt_nxt   = '0;
            dust_flag_nxt = alarm_dust;
            state_nxt     = WAIT;
         end
      end
   end

   // ------------------------------------------------------------------
   // Write-side bookkeeping, computed after this cycle's write so that a
   // swap in the same cycle publishes counts that include it.
   // ------------------------------------------------------------------
   assign full       = (wr_ptr >= (AW+1)'(N_POINTS));
   assign mem_we     = do_write & ~full;
   assign ptr_after  = wr_ptr + {{AW{1'b0}}, mem_we};
   assign ovf_after  = ovf_flag | (do_write & full);
   assign dust_after = (do_write && dust_flag && (dust_cnt != 8'hFF)) ? dust_cnt + 8'd1 : dust_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         send_prev      <= 1'b0;
         zero_prev      <= 1'b0;
         win_cnt        <= '0;
         dust_flag      <= 1'b0;
         point          <= '0;
         wr_ptr         <= '0;
         ovf_flag       <= 1'b0;
         dust_cnt       <= '0;
         wr_bank        <= 1'b0;
         synced         <= 1'b0;
         frame_ready    <= 1'b0;
         frame_count    <= '0;
         frame_overflow <= 1'b0;
         frame_dust     <= '0;
         rd_data        <= '0;
      end else begin
         send_prev   <= send_en;
         zero_prev   <= zero_flag;
         win_cnt     <= win_cnt_nxt;
         dust_flag   <= dust_flag_nxt;
         point       <= point_nxt;
         synced      <= synced_nxt;
         frame_ready <= swap;
         if (swap) begin
            frame_count    <= ptr_after;
            frame_overflow <= ovf_after;
            frame_dust     <= dust_after;
            wr_bank        <= ~wr_bank;
            wr_ptr         <= '0;
            ovf_flag       <= 1'b0;
            dust_cnt       <= '0;
         end else begin
            wr_ptr   <= ptr_after;
            ovf_flag <= ovf_after;
            dust_cnt <= dust_after;
         end
         // Follows wr_bank, so reads see the new readable bank the cycle after a swap.
         rd_data <= mem[{~wr_bank, rd_addr}];
      end
   end

   // Point storage has no reset; contents are meaningful only after a frame_ready.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[{wr_bank, wr_ptr[AW-1:0]}] <= wr_point;
      end
   end

endmodule

// File: tb/tb_scan_frame_builder.sv
module tb_scan_frame_builder;

   localparam int          N_POINTS  = 1024;
   localparam int          AW        = 10;
   localparam int          TIMEOUT   = 64;
   localparam logic [15:0] NO_TARGET = 16'hFFFF;
   localparam logic [15:0] MAX_DIST  = 16'hFFFE;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          send_en;
   logic          zero_flag;
   logic          target_valid;
   logic [31:0]   target_pos;
   logic          alarm_dust;
   logic          frame_ready;
   logic [AW:0]   frame_count;
   logic          frame_overflow;
   logic [7:0]    frame_dust;
   logic          synced;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_data;

   int errors = 0;
   int checks = 0;

   // Reference model state: one revolution as a list of points
   bit          m_synced;
   int          m_shots;
   int          m_dust;
   logic [15:0] m_cur[$];

   // Scoreboard of published frames
   int          exp_count[$];
   int          exp_ovf[$];
   int          exp_dust[$];
   logic [15:0] exp_pts[$];
   bit          mon_busy = 1'b0;

   scan_frame_builder #(
      .N_POINTS(N_POINTS), .AW(AW), .TIMEOUT(TIMEOUT),
      .NO_TARGET(NO_TARGET), .MAX_DIST(MAX_DIST)
   ) dut (
      .clk(clk), .rst_n(rst_n), .send_en(send_en), .zero_flag(zero_flag),
      .target_valid(target_valid), .target_pos(target_pos), .alarm_dust(alarm_dust),
      .frame_ready(frame_ready), .frame_count(frame_count), .frame_overflow(frame_overflow),
      .frame_dust(frame_dust), .synced(synced), .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] sat(input logic [31:0] pos);
      return (pos > 32'h0000_FFFE) ? MAX_DIST : pos[15:0];
   endfunction

   // A completed shot as the specification sees it.
   task automatic record(input logic [15:0] p, input bit dust);
      if (!m_synced) return;
      m_shots++;
      if (dust) m_dust++;
      if (m_cur.size() < N_POINTS) m_cur.push_back(p);
   endtask

   // A zero edge: publish the current revolution (if aligned) and start a new one.
   task automatic model_zero();
      if (m_synced) begin
         exp_count.push_back(m_cur.size());
         exp_ovf.push_back(m_shots > N_POINTS ? 1 : 0);
         exp_dust.push_back(m_dust > 255 ? 255 : m_dust);
         foreach (m_cur[i]) exp_pts.push_back(m_cur[i]);
      end
      m_synced = 1'b1;
      m_cur.delete();
      m_shots = 0;
      m_dust  = 0;
   endtask

   task automatic zero();
      @(negedge clk);
      zero_flag = 1'b1;
      model_zero();
      repeat (3) @(negedge clk);
      zero_flag = 1'b0;
      repeat (30) @(negedge clk);
   endtask

   // tdel < 0: no target; otherwise target_valid tdel cycles after the send_en rise (tdel >= 2).
   task automatic shot(input int tdel, input logic [31:0] pos, input bit dust, input bit dbl);
      @(negedge clk);
      send_en = 1'b1;
      alarm_dust = dust;
      if (tdel < 0) begin
         repeat (2) @(negedge clk);
         send_en = 1'b0;
         repeat (TIMEOUT + 8) @(negedge clk);
         record(NO_TARGET, dust);
      end else begin
         for (int i = 0; i < tdel; i++) begin
            @(negedge clk);
            if (i == 1) send_en = 1'b0;
         end
         target_valid = 1'b1;
         target_pos = pos;
         @(negedge clk);
         if (dbl) begin
            target_pos = pos ^ 32'h0000_0055;
            @(negedge clk);
         end
         target_valid = 1'b0;
         repeat (3) @(negedge clk);
         record(sat(pos), dust);
      end
      alarm_dust = 1'b0;
   endtask

   function automatic logic [31:0] rand_pos();
      logic [31:0] r;
      r = $urandom;
      return ($urandom_range(0, 3) == 0) ? r : {16'd0, r[15:0]};
   endfunction

   // Monitor: pops and compares one expected frame per frame_ready.
   initial begin : monitor
      int c;
      logic [15:0] pts[$];
      rd_addr = '0;
      forever begin
         @(negedge clk);
         if (frame_ready === 1'b1) begin
            mon_busy = 1'b1;
            if (exp_count.size() == 0) begin
               check("unexpected_frame_ready", 32'd1, 32'd0);
            end else begin
               c = exp_count.pop_front();
               check("frame_count", 32'(frame_count), 32'(c));
               check("frame_overflow", 32'(frame_overflow), 32'(exp_ovf.pop_front()));
               check("frame_dust", 32'(frame_dust), 32'(exp_dust.pop_front()));
               pts.delete();
               for (int i = 0; i < c; i++) pts.push_back(exp_pts.pop_front());
               rd_addr = '0;
               @(negedge clk);
               check("frame_ready_width", 32'(frame_ready), 32'd0);
               for (int i = 0; i < c; i++) begin
                  if (c <= 16 || i < 4 || i >= c - 4) begin
                     rd_addr = AW'(i);
                     @(negedge clk);
                     check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(pts[i]));
                  end
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      rst_n = 1'b0; send_en = 1'b0; zero_flag = 1'b0; target_valid = 1'b0;
      target_pos = '0; alarm_dust = 1'b0;
      m_synced = 1'b0; m_shots = 0; m_dust = 0;
      repeat (3) @(negedge clk);
      check("rst_frame_ready", 32'(frame_ready), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_frame_overflow", 32'(frame_overflow), 32'd0);
      check("rst_frame_dust", 32'(frame_dust), 32'd0);
      check("rst_synced", 32'(synced), 32'd0);
      check("rst_rd_data", 32'(rd_data), 32'd0);
      rst_n = 1'b1;

      // Shots before alignment are dropped and raise no frame.
      for (int i = 0; i < 3; i++) shot(5, rand_pos(), 1'b1, 1'b0);
      check("synced_before_zero", 32'(synced), 32'd0);
      zero();
      check("synced_after_zero", 32'(synced), 32'd1);

      // Basic three-point frame.
      shot(10, 32'd1000, 1'b0, 1'b0);
      shot(10, 32'd1250, 1'b0, 1'b0);
      shot(10, 32'd1500, 1'b0, 1'b0);
      zero();

      // Miss, saturation, boundaries, double pulse, retrigger, random shots.
      shot(-1, 32'd0, 1'b0, 1'b0);
      shot(10, 32'h0001_2345, 1'b1, 1'b0);
      shot(10, 32'h0000_FFFF, 1'b0, 1'b0);
      shot(10, 32'h0000_FFFE, 1'b0, 1'b0);
      shot(60, 32'd4321, 1'b0, 1'b0);
      shot(4, 32'd777, 1'b1, 1'b1);
      @(negedge clk);
      send_en = 1'b1;
      alarm_dust = 1'b1;
      repeat (2) @(negedge clk);
      send_en = 1'b0;
      repeat (18) @(negedge clk);
      record(NO_TARGET, 1'b1);
      shot(10, 32'd2222, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if ($urandom_range(0, 4) == 0) shot(-1, 32'd0, 1'($urandom_range(0, 1)), 1'b0);
         else shot(int'($urandom_range(2, 40)), rand_pos(), 1'($urandom_range(0, 1)), 1'b0);
      end
      zero();

      // Overflowing revolution, then a normal one.
      for (int i = 0; i < 1030; i++) shot(2, rand_pos(), 1'($urandom_range(0, 1)), 1'b0);
      zero();
      shot(3, rand_pos(), 1'b0, 1'b0);
      shot(3, rand_pos(), 1'b0, 1'b0);
      zero();

      // Zero edge mid-window: the shot vanishes; a late target is ignored.
      shot(5, 32'd100, 1'b0, 1'b0);
      @(negedge clk);
      send_en = 1'b1;
      alarm_dust = 1'b1;
      repeat (2) @(negedge clk);
      send_en = 1'b0;
      repeat (5) @(negedge clk);
      zero();
      target_valid = 1'b1;
      target_pos = 32'd9999;
      @(negedge clk);
      target_valid = 1'b0;
      repeat (3) @(negedge clk);

      // Zero edge coinciding with a send edge: shot belongs to the new frame.
      shot(5, 32'd200, 1'b0, 1'b0);
      @(negedge clk);
      zero_flag = 1'b1;
      send_en = 1'b1;
      model_zero();
      repeat (2) @(negedge clk);
      send_en = 1'b0;
      @(negedge clk);
      zero_flag = 1'b0;
      repeat (7) @(negedge clk);
      target_valid = 1'b1;
      target_pos = 32'd333;
      @(negedge clk);
      target_valid = 1'b0;
      repeat (3) @(negedge clk);
      record(16'd333, 1'b0);
      repeat (30) @(negedge clk);
      shot(6, rand_pos(), 1'b0, 1'b0);
      zero();

      // Dust saturation, then an empty revolution.
      for (int i = 0; i < 300; i++) shot(2, rand_pos(), 1'b1, 1'b0);
      zero();
      zero();

      // Reset mid-frame: realignment needed before the next frame.
      shot(5, rand_pos(), 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_synced", 32'(synced), 32'd0);
      check("midrst_frame_count", 32'(frame_count), 32'd0);
      m_synced = 1'b0;
      m_cur.delete();
      m_shots = 0;
      m_dust = 0;
      @(negedge clk);
      rst_n = 1'b1;
      shot(5, rand_pos(), 1'b1, 1'b0);
      zero();
      check("resync_after_reset", 32'(synced), 32'd1);
      for (int i = 0; i < 5; i++) shot(int'($urandom_range(2, 30)), rand_pos(), 1'($urandom_range(0, 1)), 1'b0);
      zero();

      for (int i = 0; i < 400 && (exp_count.size() != 0 || mon_busy); i++) @(negedge clk);
      check("scoreboard_drained", 32'(exp_count.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
